fwd_hazard_scoreboard: RTL
==========================

// Module: fwd_hazard_scoreboard
// PURPOSE
//  Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core.
//  Keeps its own shift register of in-flight destination tags: EX stage plus NUM_FWD post-EX stages.
//  Outputs per-source forward selects for the instruction in EX.
//  Raises stall_o when an ID instruction depends on a load whose data will not be ready in time.
//  Replaces the EX_MEM/MEM_WB address plumbing into the datapath forwarding muxes.
// PARAMETERS
//  ADDR_W   5   register address width
//  NUM_SRC  2   source operands per instruction
//  NUM_FWD  2   forwardable post-EX stages (1=EX/MEM, 2=MEM/WB, ...)
//  LOAD_LAT 1   post-EX stages until load data exists; legal range 1..NUM_FWD-1
//  SEL_W    $clog2(NUM_FWD+1)  forward select width (derived)
//  CNT_W    32  stall counter width
// PORTS
//  clk_i          in   1               clock, rising edge
//  rst_i          in   1               asynchronous reset, active-low
//  id_valid_i     in   1               ID holds a real instruction
//  id_rs_addr_i   in   NUM_SRC*ADDR_W  ID source addresses; src i at [i*ADDR_W +: ADDR_W]
//  id_rs_used_i   in   NUM_SRC         source i is actually read
//  id_rd_addr_i   in   ADDR_W          ID destination
//  id_regwrite_i  in   1               ID writes rd
//  id_memread_i   in   1               ID is a load
//  freeze_i       in   1               global pipeline hold (memory stall)
//  flush_i        in   1               kill instruction leaving ID (branch taken)
//  stall_o        out  1               load-use stall: hold PC and IF/ID, bubble into EX
//  fwd_sel_o      out  NUM_SRC*SEL_W   per EX source: 0=regfile, k=forward from post-EX stage k
//  stall_cnt_o    out  CNT_W           load-use stall cycle count
// BEHAVIOUR
//  Reset (async, rst_i=0):
//   - all tag entries invalid; EX source-used flags 0; counter 0
//   - stall_o=0; fwd_sel_o=0
//  Tag entry fields: {valid, rd, regwrite, memread}.
//   - entry "writes" when valid & regwrite & rd!=0; x0 never forwards or stalls
//  Clocking:
//   - freeze_i=1: every register holds; flush_i ignored (upstream keeps it asserted)
//   - otherwise: stage[k] <= stage[k-1] for k=1..NUM_FWD; stage NUM_FWD's old entry drops out
//   - stage0 and EX rs addr/used <= ID values when id_valid_i & !stall_o & !flush_i
//   - else stage0 <= bubble and EX used flags <= 0
//  ready(k) = !memread | (k >= 1+LOAD_LAT).
//  Forwarding (combinational from registered EX state, zero latency):
//   - for each used EX src, pick the smallest k in 1..NUM_FWD whose writing entry matches rs; sel=k
//   - no match gives sel=0
//   - the youngest match always wins, even over older matches
//  Stall (combinational):
//   - for each used ID src with id_valid_i, take the youngest writing match k in 0..NUM_FWD-1
//   - stall_o=1 iff that entry is a load and k < LOAD_LAT
//   - an older load masked by a younger non-load match does not stall
//   - a load-use stall lasts LOAD_LAT-k cycles
//  A producer leaving stage NUM_FWD is covered by the regfile write-before-read; no stall, sel=0.
//  Counter: +1 each cycle stall_o & !freeze_i; saturates at all-ones.
//  Invariant: the youngest EX match is never a not-ready entry; the bench asserts this.
// STRUCTURE
//  fwd_defs.vh: SEL_REGFILE=0, tag field offsets, LOAD_LAT range check.
//  Sub-module fwd_src_match: one source vs all tag entries.
//   - outputs youngest-match index and hit
//   - instantiated NUM_SRC times for EX and NUM_SRC times for ID
// TESTING (defaults unless noted)
//  1 add x5; sub x6,x5,x1 back-to-back -> src0 sel=1, stall_o=0
//  2 add x5; nop; or x7,x5,x5 -> both srcs sel=2
//  3 lw x7; add x8,x7,x2 -> stall_o=1 exactly 1 cycle, add in EX with src0 sel=2, stall_cnt_o=1
//  4 add x0,x1,x2; sub x3,x0,x0 -> sel=0, stall_o=0; add x3 twice then use x3 -> sel=1
//  5 NUM_FWD=3, LOAD_LAT=2: lw x9; add uses x9 -> stall 2 cycles, then sel=3
//    - freeze_i pulsed mid-stall holds stall_o and the counter
//  6 rst_i low mid-stall -> stall_o, fwd_sel_o, stall_cnt_o = 0 immediately; first post-reset use forwards nothing

Source files
------------

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
// A tag entry is a flat vector {rd, valid, regwrite, memread}.
package fwd_hazard_scoreboard_pkg;

    localparam int SEL_REGFILE  = 0;  // forward select meaning "read the register file"

    // bit offsets inside a tag entry
    localparam int TAG_MEMREAD  = 0;
    localparam int TAG_REGWRITE = 1;
    localparam int TAG_VALID    = 2;
    localparam int TAG_RD_LSB   = 3;

    function automatic int tag_w(input int addr_w);
        return addr_w + 3;
    endfunction

    // load data must appear inside the forwarding window, otherwise no amount of stalling helps
    function automatic bit lat_ok(input int load_lat, input int num_fwd);
        return (load_lat >= 1) && (load_lat < num_fwd);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Compares one source register against a window of tag entries and reports
// the youngest (lowest index) entry that writes that register.
module fwd_src_match
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int NUM_ENT = 2,
    parameter int IDX_W   = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1
) (
    input  logic                             en,
    input  logic [ADDR_W-1:0]                rs_addr,
    input  logic [NUM_ENT*tag_w(ADDR_W)-1:0] tags,
    output logic                             hit,
    output logic [IDX_W-1:0]                 idx,
    output logic                             hit_load
);

    localparam int TAG_W = tag_w(ADDR_W);

    logic [TAG_W-1:0] ent;

    // scan oldest to youngest so the youngest writer overrides any older one
    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        hit_load = 1'b0;
        ent      = '0;
        for (int j = NUM_ENT - 1; j >= 0; j--) begin
            ent = tags[j*TAG_W +: TAG_W];
            if (en && ent[TAG_VALID] && ent[TAG_REGWRITE] &&
                (ent[TAG_RD_LSB +: ADDR_W] != '0) &&
                (ent[TAG_RD_LSB +: ADDR_W] == rs_addr)) begin
                hit      = 1'b1;
                idx      = IDX_W'(j);
                hit_load = ent[TAG_MEMREAD];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and load-use stall generation for the pipelined core.
// Tracks destination tags for EX (stage 0) and NUM_FWD post-EX stages.
module fwd_hazard_scoreboard
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(NUM_FWD + 1),
    parameter int CNT_W    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr_i,
    input  logic [NUM_SRC-1:0]        id_rs_used_i,
    input  logic [ADDR_W-1:0]         id_rd_addr_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    input  logic                      freeze_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam int TAG_W = tag_w(ADDR_W);
    localparam int IDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;
    localparam logic [IDX_W-1:0] LAT_IDX = IDX_W'(LOAD_LAT);

    if (!lat_ok(LOAD_LAT, NUM_FWD)) begin : g_bad_load_lat
        $error("fwd_hazard_scoreboard: LOAD_LAT must lie in 1..NUM_FWD-1");
    end

    logic [NUM_FWD:0][TAG_W-1:0]     stage_q;   // [0]=EX, [k]=post-EX stage k
    logic [NUM_SRC-1:0][ADDR_W-1:0]  ex_rs_q;
    logic [NUM_SRC-1:0]              ex_used_q;
    logic [CNT_W-1:0]                stall_cnt_q;

    logic                            issue;
    logic [TAG_W-1:0]                id_tag;
    logic [NUM_FWD*TAG_W-1:0]        ex_view;   // entry j = post-EX stage j+1
    logic [NUM_FWD*TAG_W-1:0]        id_view;   // entry j = stage j (EX included)

    logic [NUM_SRC-1:0]              ex_hit, ex_hit_load;
    logic [NUM_SRC-1:0][IDX_W-1:0]   ex_idx;
    logic [NUM_SRC-1:0]              id_hit, id_hit_load, id_src_stall;
    logic [NUM_SRC-1:0][IDX_W-1:0]   id_idx;
    logic                            ex_load_unused;

    assign issue   = id_valid_i & ~stall_o & ~flush_i;
    assign id_tag  = {id_rd_addr_i, 1'b1, id_regwrite_i, id_memread_i};
    assign ex_view = stage_q[NUM_FWD:1];
    assign id_view = stage_q[NUM_FWD-1:0];

    // EX selection only needs the youngest writer; whether it is a load is
    // already excluded by the stall, so that flag is deliberately dropped here
    assign ex_load_unused = |ex_hit_load;

    // tag shift register plus the EX source operands; freeze holds everything
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stage_q   <= '0;
            ex_rs_q   <= '0;
            ex_used_q <= '0;
        end else if (!freeze_i) begin
            for (int k = 1; k <= NUM_FWD; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
            if (issue) begin
                stage_q[0] <= id_tag;
                ex_rs_q    <= id_rs_addr_i;
                ex_used_q  <= id_rs_used_i;
            end else begin
                stage_q[0] <= '0;
                ex_used_q  <= '0;
            end
        end
    end

    // saturating count of load-use stall cycles that actually cost a cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && !freeze_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .ADDR_W  (ADDR_W),
            .NUM_ENT (NUM_FWD),
            .IDX_W   (IDX_W)
        ) u_ex_match (
            .en       (ex_used_q[s]),
            .rs_addr  (ex_rs_q[s]),
            .tags     (ex_view),
            .hit      (ex_hit[s]),
            .idx      (ex_idx[s]),
            .hit_load (ex_hit_load[s])
        );

        fwd_src_match #(
            .ADDR_W  (ADDR_W),
            .NUM_ENT (NUM_FWD),
            .IDX_W   (IDX_W)
        ) u_id_match (
            .en       (id_valid_i & id_rs_used_i[s]),
            .rs_addr  (id_rs_addr_i[s*ADDR_W +: ADDR_W]),
            .tags     (id_view),
            .hit      (id_hit[s]),
            .idx      (id_idx[s]),
            .hit_load (id_hit_load[s])
        );

        assign fwd_sel_o[s*SEL_W +: SEL_W] = ex_hit[s] ? (SEL_W'(ex_idx[s]) + SEL_W'(1))
                                                       : SEL_W'(SEL_REGFILE);
        // only the youngest writer counts: a younger ALU result masks an older load
        assign id_src_stall[s] = id_hit[s] & id_hit_load[s] & (id_idx[s] < LAT_IDX);
    end

    assign stall_o     = |id_src_stall;
    assign stall_cnt_o = stall_cnt_q;

endmodule
